// File: rtl/alu_op_queue.sv
// alu_op_queue: operand/issue stage in front of a 4-bit AND/ADD ALU.
// Ops from the producer are buffered in a DEPTH-entry FIFO. The head entry
// drives the ALU inputs, and the ALU result is captured into an output
// register that is handed to the consumer over a valid/ready handshake.
// Optional feature macro: ALU_Q_STATS_EN adds an 8-bit delivered-result
// counter on port done_cnt.
module alu_op_queue #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sel,
  input  logic             in_cin,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_sel,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
`ifdef ALU_Q_STATS_EN
  output logic [PTR_W:0]   count,
  output logic [7:0]       done_cnt
`else
  output logic [PTR_W:0]   count
`endif
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] ZERO_C  = '0;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sel;
    logic             cin;
  } entry_t;

  // Pack the producer fields into one FIFO entry.
  function automatic entry_t pack_entry(input logic [WIDTH-1:0] a,
                                        input logic [WIDTH-1:0] b,
                                        input logic             sel,
                                        input logic             cin);
    entry_t e;
    e.a   = a;
    e.b   = b;
    e.sel = sel;
    e.cin = cin;
    return e;
  endfunction

  entry_t           mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic [PTR_W:0]   count_nxt_s;
  logic             out_valid_r;
  logic [WIDTH-1:0] out_result_r;
  logic             push_s;
  logic             issue_s;
  logic             deliver_s;
  logic             not_empty_s;
  entry_t           head_s;

  // Handshake qualifiers: a full FIFO blocks pushes even while popping.
  always_comb begin
    not_empty_s = (count_r != ZERO_C);
    in_ready    = (count_r != DEPTH_C);
    push_s      = in_valid && in_ready;
    issue_s     = not_empty_s && (!out_valid_r || out_ready);
    deliver_s   = out_valid_r && out_ready;
    head_s      = mem_r[rd_ptr_r];
  end

  // Next occupancy: simultaneous push and issue leave the count unchanged.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, issue_s})
      2'b10:   count_nxt_s = count_r + (PTR_W+1)'(1);
      2'b01:   count_nxt_s = count_r - (PTR_W+1)'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Drive the head entry onto the ALU, or all zeros while the FIFO is empty.
  always_comb begin
    alu_a   = {WIDTH{1'b0}};
    alu_b   = {WIDTH{1'b0}};
    alu_sel = 1'b0;
    alu_cin = 1'b0;
    if (not_empty_s) begin
      alu_a   = head_s.a;
      alu_b   = head_s.b;
      alu_sel = head_s.sel;
      alu_cin = head_s.cin;
    end else begin
      alu_a   = {WIDTH{1'b0}};
      alu_b   = {WIDTH{1'b0}};
      alu_sel = 1'b0;
      alu_cin = 1'b0;
    end
  end

  // FIFO storage write; entries are cleared on reset so nothing stale leaks out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= pack_entry(in_a, in_b, in_sel, in_cin);
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= ZERO_C;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (issue_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_nxt_s;
    end
  end

  // Output register: capture the ALU result on issue, drop valid on bare delivery.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r  <= 1'b0;
      out_result_r <= {WIDTH{1'b0}};
    end else if (issue_s) begin
      out_valid_r  <= 1'b1;
      out_result_r <= alu_result;
    end else if (deliver_s) begin
      out_valid_r  <= 1'b0;
    end
  end

  assign out_valid  = out_valid_r;
  assign out_result = out_result_r;
  assign count      = count_r;

`ifdef ALU_Q_STATS_EN
  logic [7:0] done_cnt_r;

  // Count delivered results, wrapping 255 -> 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_cnt_r <= 8'd0;
    end else if (deliver_s) begin
      done_cnt_r <= done_cnt_r + 8'd1;
    end
  end

  assign done_cnt = done_cnt_r;
`endif

endmodule

// File: tb/tb_alu_op_queue.sv
// Directed self-checking bench for alu_op_queue, with a behavioural
// AND/ADD ALU closing the loop from alu_* back to alu_result.
module tb_alu_op_queue;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic       in_sel;
  logic       in_cin;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic       alu_sel;
  logic       alu_cin;
  logic [3:0] alu_result;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_result;
  logic [2:0] count;
`ifdef ALU_Q_STATS_EN
  logic [7:0] done_cnt;
`endif

  int errors = 0;
  int checks = 0;

  alu_op_queue #(.WIDTH(4), .DEPTH(4), .PTR_W(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_sel     (in_sel),
    .in_cin     (in_cin),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_cin    (alu_cin),
    .alu_result (alu_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
`ifdef ALU_Q_STATS_EN
    .count      (count),
    .done_cnt   (done_cnt)
`else
    .count      (count)
`endif
  );

  // Reference ALU: sel=0 AND, sel=1 ADD with carry-in, carry-out dropped.
  assign alu_result = alu_sel ? (alu_a + alu_b + {3'b000, alu_cin}) : (alu_a & alu_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs change and checks happen on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b,
                       input logic s, input logic c);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    in_sel   = s;
    in_cin   = c;
  endtask

  logic [3:0] bp_exp [5];
  logic [3:0] st_exp [8];

  initial begin
    bp_exp = '{4'h1, 4'h3, 4'h5, 4'h7, 4'h9};
    st_exp = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0, 4'h1};

    rst_n     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    #12;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_result", 32'(out_result), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef ALU_Q_STATS_EN
    chk("rst_done_cnt", 32'(done_cnt), 32'd0);
`endif

    // AND: 1100 & 1010 = 1000, result one cycle after the push.
    out_ready = 1'b1;
    drive(1'b1, 4'b1100, 4'b1010, 1'b0, 1'b0);
    step();
    drive(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    chk("and_count_after_push", 32'(count), 32'd1);
    chk("and_alu_a_head", 32'(alu_a), 32'hC);
    chk("and_out_valid_pre", 32'(out_valid), 32'd0);
    step();
    chk("and_out_valid", 32'(out_valid), 32'd1);
    chk("and_out_result", 32'(out_result), 32'h8);
    chk("and_count_after_issue", 32'(count), 32'd0);
    chk("and_alu_a_empty", 32'(alu_a), 32'd0);
    step();
    chk("and_delivered", 32'(out_valid), 32'd0);
    chk("and_result_held", 32'(out_result), 32'h8);

    // ADD: 7+5+1 = 13, then F+1+0 wraps to 0.
    drive(1'b1, 4'd7, 4'd5, 1'b1, 1'b1);
    step();
    drive(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    step();
    chk("add_out_valid", 32'(out_valid), 32'd1);
    chk("add_result_13", 32'(out_result), 32'd13);
    drive(1'b1, 4'hF, 4'h1, 1'b1, 1'b0);
    step();
    drive(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    chk("add_delivered", 32'(out_valid), 32'd0);
    step();
    chk("add_wrap_valid", 32'(out_valid), 32'd1);
    chk("add_wrap_result", 32'(out_result), 32'h0);
    step();
    chk("add_wrap_delivered", 32'(out_valid), 32'd0);

    // Backpressure: six ops with out_ready low; five fit (4 FIFO + 1 output).
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("bp_in_ready_%0d", i), 32'(in_ready), (i < 5) ? 32'd1 : 32'd0);
      drive(1'b1, 4'(i + 1), 4'(i), 1'b1, 1'b0);
      step();
    end
    chk("bp_count_full", 32'(count), 32'd4);
    chk("bp_in_ready_full", 32'(in_ready), 32'd0);
    chk("bp_first_valid", 32'(out_valid), 32'd1);
    chk("bp_first_result", 32'(out_result), 32'h1);
    chk("bp_alu_a_head", 32'(alu_a), 32'h2);
    step();
    chk("bp_hold_result", 32'(out_result), 32'h1);
    chk("bp_hold_alu_a", 32'(alu_a), 32'h2);
    chk("bp_hold_count", 32'(count), 32'd4);
    drive(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    out_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      step();
      chk($sformatf("bp_drain_valid_%0d", k), 32'(out_valid), 32'd1);
      chk($sformatf("bp_drain_result_%0d", k), 32'(out_result), 32'(bp_exp[k]));
    end
    step();
    chk("bp_drain_done_valid", 32'(out_valid), 32'd0);
    chk("bp_drain_done_count", 32'(count), 32'd0);

    // Streaming: one result per cycle, occupancy never above one.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 4'(i), 4'd9, 1'b1, 1'b1);
      step();
      chk($sformatf("st_count_%0d", i), 32'(count <= 3'd1), 32'd1);
      if (i >= 1) begin
        chk($sformatf("st_valid_%0d", i), 32'(out_valid), 32'd1);
        chk($sformatf("st_result_%0d", i), 32'(out_result), 32'(st_exp[i-1]));
      end
    end
    drive(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    step();
    chk("st_last_valid", 32'(out_valid), 32'd1);
    chk("st_last_result", 32'(out_result), 32'(st_exp[7]));
    chk("st_last_count", 32'(count), 32'd0);
    step();
    chk("st_done_valid", 32'(out_valid), 32'd0);

    // Reset mid-operation: 3 queued plus a pending result, all dropped at once.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'(i + 3), 4'h2, 1'b0, 1'b0);
      step();
    end
    drive(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    chk("rm_pre_count", 32'(count), 32'd3);
    chk("rm_pre_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rm_async_valid", 32'(out_valid), 32'd0);
    chk("rm_async_count", 32'(count), 32'd0);
    chk("rm_async_result", 32'(out_result), 32'd0);
    step();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("rm_post_valid_%0d", k), 32'(out_valid), 32'd0);
      chk($sformatf("rm_post_ready_%0d", k), 32'(in_ready), 32'd1);
      chk($sformatf("rm_post_count_%0d", k), 32'(count), 32'd0);
    end

`ifdef ALU_Q_STATS_EN
    // 257 deliveries after reset wrap the 8-bit counter to 1.
    for (int i = 0; i < 257; i++) begin
      drive(1'b1, 4'(i), 4'h1, 1'b0, 1'b0);
      step();
    end
    drive(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    step();
    step();
    chk("stats_out_valid_idle", 32'(out_valid), 32'd0);
    chk("stats_done_cnt_257", 32'(done_cnt), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
